pc_step_counter: RTL and testbench



---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_step_adder.sv | 38 +++
 rtl/pc_step_counter.sv | 102 ++++++++++
 tb/tb_pc_step_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// +----------------------------------------------------------------------+
// | pc_pkg : command encoding and default sizes for the PC step counter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pc_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD    = 2'b00,
        CMD_INC     = 2'b01,
        CMD_ADD_OFF = 2'b10,
        CMD_LOAD    = 2'b11
    } pc_cmd_t;

    localparam int c_default_width = 32;
    localparam int c_default_step  = 1;

endpackage

`default_nettype wire

// File: rtl/pc_step_adder.sv
// +----------------------------------------------------------------------+
// | pc_step_adder : WIDTH-bit adder with boundary-crossing detection     |
// | Optional macro PC_SATURATE_EN clamps the sum instead of wrapping.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_step_adder
    import pc_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_wrap
);

    logic [WIDTH:0] w_ext;
    logic           w_cross;

    assign w_ext = {1'b0, i_a} + {1'b0, i_b};

    // A negative operand in two's complement borrows exactly when there is no carry out.
    assign w_cross = i_neg ? ~w_ext[WIDTH] : w_ext[WIDTH];

`ifdef PC_SATURATE_EN
    assign o_sum = w_cross ? (i_neg ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : w_ext[WIDTH-1:0];
`else
    assign o_sum = w_ext[WIDTH-1:0];
`endif

    assign o_wrap = w_cross;

endmodule

`default_nettype wire

// File: rtl/pc_step_counter.sv
// +----------------------------------------------------------------------+
// | pc_step_counter : registered program counter (hold/inc/offset/load)  |
// | Optional macro PC_SATURATE_EN: INC/ADD_OFF saturate instead of wrap. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_step_counter
    import pc_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter int               STEP      = c_default_step,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] load_val,
    input  logic             stall,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap,
    output logic             busy_ld
);

    localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

    pc_cmd_t          w_cmd_eff;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_neg;
    logic [WIDTH-1:0] w_add_sum;
    logic             w_add_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_busy_ld;

    assign w_cmd_eff = stall ? CMD_HOLD : pc_cmd_t'(cmd);
    assign w_add_b   = (w_cmd_eff == CMD_ADD_OFF) ? offset : c_step;
    assign w_add_neg = (w_cmd_eff == CMD_ADD_OFF) && offset[WIDTH-1];

    pc_step_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (r_count),
        .i_b    (w_add_b),
        .i_neg  (w_add_neg),
        .o_sum  (w_add_sum),
        .o_wrap (w_add_wrap)
    );

    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        case (w_cmd_eff)
            CMD_HOLD: begin
                w_next = r_count;
                w_wrap = 1'b0;
            end
            CMD_INC, CMD_ADD_OFF: begin
                w_next = w_add_sum;
                w_wrap = w_add_wrap;
            end
            CMD_LOAD: begin
                w_next = load_val;
                w_wrap = 1'b0;
            end
            default: begin
                w_next = r_count;
                w_wrap = 1'b0;
            end
        endcase
        // The preview must already show the reset value while reset is held.
        if (!rst_n) begin
            w_next = RESET_VAL;
            w_wrap = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= RESET_VAL;
            r_wrap    <= 1'b0;
            r_busy_ld <= 1'b0;
        end else begin
            r_count   <= w_next;
            r_wrap    <= w_wrap;
            r_busy_ld <= (w_cmd_eff == CMD_LOAD);
        end
    end

    assign count      = r_count;
    assign count_next = w_next;
    assign wrap       = r_wrap;
    assign busy_ld    = r_busy_ld;

endmodule

`default_nettype wire

// File: tb/tb_pc_step_counter.sv
// +----------------------------------------------------------------------+
// | tb_pc_step_counter : directed + model-checked bench, STEP=1 and 4    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pc_step_counter;

    logic       clk;
    logic       rst_n;
    logic [1:0] cmd;
    logic [7:0] offset;
    logic [7:0] load_val;
    logic       stall;

    logic [7:0] count_a, count_next_a, count_b, count_next_b;
    logic       wrap_a, busy_a, wrap_b, busy_b;

    int n_checks;
    int n_errors;

    pc_step_counter #(.WIDTH(8), .STEP(1), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .offset(offset), .load_val(load_val),
        .stall(stall), .count(count_a), .count_next(count_next_a), .wrap(wrap_a),
        .busy_ld(busy_a)
    );

    pc_step_counter #(.WIDTH(8), .STEP(4), .RESET_VAL(8'h00)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .offset(offset), .load_val(load_val),
        .stall(stall), .count(count_b), .count_next(count_next_b), .wrap(wrap_b),
        .busy_ld(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer-domain reference: {busy_ld, wrap, next}
    function automatic logic [9:0] ref_step(input logic [7:0] c, input logic [1:0] cm,
                                            input logic [7:0] off, input logic [7:0] ld,
                                            input logic st, input int step);
        int r;
        if (st || cm == 2'b00) return {2'b00, c};
        if (cm == 2'b11) return {2'b10, ld};
        if (cm == 2'b01) r = int'(c) + step;
        else             r = int'(c) + int'($signed(off));
`ifdef PC_SATURATE_EN
        if (r > 255) return {2'b01, 8'hFF};
        if (r < 0)   return {2'b01, 8'h00};
`else
        if (r > 255) return {2'b01, 8'(r - 256)};
        if (r < 0)   return {2'b01, 8'(r + 256)};
`endif
        return {2'b00, 8'(r)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] off,
                         input logic [7:0] ld, input logic st);
        cmd = c; offset = off; load_val = ld; stall = st;
    endtask

    logic [9:0] exp_a, exp_b;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(2'b01, 8'h00, 8'h00, 1'b0);

        // Reset held for two edges with INC requested
        #1;
        check("rst_count_next_a", 32'(count_next_a), 32'h00);
        cycle();
        cycle();
        check("rst_count_a", 32'(count_a), 32'h00);
        check("rst_wrap_a", 32'(wrap_a), 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);

        // First INC after deassert starts from RESET_VAL
        rst_n = 1'b1;
        cycle(); check("inc1_a", 32'(count_a), 32'h01);
        cycle(); check("inc2_a", 32'(count_a), 32'h02);
        cycle(); check("inc3_a", 32'(count_a), 32'h03);
        check("inc_wrap_a", 32'(wrap_a), 32'h0);
        check("inc_busy_a", 32'(busy_a), 32'h0);

        // Boundary crossing with STEP=4 from FE
        drive(2'b11, 8'h00, 8'hFE, 1'b0);
        cycle();
        check("ldfe_count_b", 32'(count_b), 32'hFE);
        check("ldfe_busy_b", 32'(busy_b), 32'h1);
        drive(2'b01, 8'h00, 8'h00, 1'b0);
        cycle();
`ifdef PC_SATURATE_EN
        check("incwrap_count_b", 32'(count_b), 32'hFF);
`else
        check("incwrap_count_b", 32'(count_b), 32'h02);
`endif
        check("incwrap_wrap_b", 32'(wrap_b), 32'h1);
        check("incwrap_busy_b", 32'(busy_b), 32'h0);
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        cycle();
        check("hold_wrap_clear_b", 32'(wrap_b), 32'h0);

        // STEP=1 at all-ones
        drive(2'b11, 8'h00, 8'hFF, 1'b0);
        cycle();
        drive(2'b01, 8'h00, 8'h00, 1'b0);
        cycle();
`ifdef PC_SATURATE_EN
        check("ff_inc_count_a", 32'(count_a), 32'hFF);
`else
        check("ff_inc_count_a", 32'(count_a), 32'h00);
`endif
        check("ff_inc_wrap_a", 32'(wrap_a), 32'h1);

        // Signed offsets
        drive(2'b11, 8'h00, 8'h10, 1'b0);
        cycle();
        drive(2'b10, 8'hF0, 8'h00, 1'b0);
        cycle();
        check("off_m16_count_a", 32'(count_a), 32'h00);
        check("off_m16_wrap_a", 32'(wrap_a), 32'h0);
        drive(2'b10, 8'hFF, 8'h00, 1'b0);
        cycle();
`ifdef PC_SATURATE_EN
        check("off_m1_count_a", 32'(count_a), 32'h00);
`else
        check("off_m1_count_a", 32'(count_a), 32'hFF);
`endif
        check("off_m1_wrap_a", 32'(wrap_a), 32'h1);
        drive(2'b11, 8'h00, 8'h5A, 1'b0);
        cycle();
        drive(2'b10, 8'h00, 8'h00, 1'b0);
        cycle();
        check("off_0_count_a", 32'(count_a), 32'h5A);
        check("off_0_wrap_a", 32'(wrap_a), 32'h0);
        drive(2'b10, 8'h21, 8'h00, 1'b0);
        cycle();
        check("off_p33_count_a", 32'(count_a), 32'h7B);

        // Stall blocks a LOAD
        drive(2'b11, 8'h00, 8'h20, 1'b0);
        cycle();
        drive(2'b11, 8'h00, 8'h80, 1'b1);
        cycle();
        check("stall1_count_a", 32'(count_a), 32'h20);
        check("stall1_busy_a", 32'(busy_a), 32'h0);
        cycle();
        check("stall2_count_a", 32'(count_a), 32'h20);
        check("stall2_busy_a", 32'(busy_a), 32'h0);
        stall = 1'b0;
        cycle();
        check("unstall_count_a", 32'(count_a), 32'h80);
        check("unstall_busy_a", 32'(busy_a), 32'h1);

        // Reset in the middle of an INC stream, LOAD requested at the same edge
        drive(2'b11, 8'h00, 8'h37, 1'b0);
        cycle();
        drive(2'b01, 8'h00, 8'h00, 1'b0);
        cycle();
        check("pre_rst_count_a", 32'(count_a), 32'h38);
        rst_n = 1'b0;
        drive(2'b11, 8'h00, 8'hC3, 1'b0);
        #1;
        check("rst_preview_a", 32'(count_next_a), 32'h00);
        cycle();
        check("midrst_count_a", 32'(count_a), 32'h00);
        check("midrst_wrap_a", 32'(wrap_a), 32'h0);
        check("midrst_busy_a", 32'(busy_a), 32'h0);
        rst_n = 1'b1;
        drive(2'b01, 8'h00, 8'h00, 1'b0);
        cycle();
        check("postrst_inc_a", 32'(count_a), 32'h01);
        check("postrst_inc_b", 32'(count_b), 32'h04);

        // Random commands against the reference model
        for (int i = 0; i < 200; i++) begin
            drive(2'($urandom_range(3)), 8'($urandom), 8'($urandom), ($urandom_range(4) == 0));
            #1;
            exp_a = ref_step(count_a, cmd, offset, load_val, stall, 1);
            exp_b = ref_step(count_b, cmd, offset, load_val, stall, 4);
            check("rnd_next_a", 32'(count_next_a), 32'(exp_a[7:0]));
            check("rnd_next_b", 32'(count_next_b), 32'(exp_b[7:0]));
            cycle();
            check("rnd_count_a", 32'(count_a), 32'(exp_a[7:0]));
            check("rnd_wrap_a", 32'(wrap_a), 32'(exp_a[8]));
            check("rnd_busy_a", 32'(busy_a), 32'(exp_a[9]));
            check("rnd_count_b", 32'(count_b), 32'(exp_b[7:0]));
            check("rnd_wrap_b", 32'(wrap_b), 32'(exp_b[8]));
            check("rnd_busy_b", 32'(busy_b), 32'(exp_b[9]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
